life_scan_reader: RTL and testbench

LIFE_SCAN_READER -- requirements
Module: life_scan_reader

---
 rtl/life_scan_reader.sv | 160 ++++++++++++++++
 tb/tb_life_scan_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_scan_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : life_scan_reader                                         |
// | Description : Unloads a cell-array scan chain of CELLS cells, packing  |
// |               the shifted-out cell states LSB first into WIDTH-bit     |
// |               words on a valid/ready output. With keep=1 the chain is  |
// |               rotated so the array ends in its original state.         |
// | Ports       : clk, reset (async, active-low)                           |
// |               start, keep       - unload request / non-destructive sel |
// |               scan_out          - cell state at the chain output end   |
// |               scan, scan_in     - chain shift enable / chain input bit |
// |               data, data_valid, data_ready - packed word handshake     |
// |               busy, done        - unload in progress / completion pulse|
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module life_scan_reader #(
  parameter int CELLS = 256,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             keep,
  input  logic             scan_out,
  output logic             scan,
  output logic             scan_in,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(CELLS + 1);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last_cell = CW'(CELLS - 1);
  localparam logic [PW-1:0] c_last_pos  = PW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;     // captures taken this unload
  logic [PW-1:0]    pos_q, pos_d;     // next packer bit position
  logic [WIDTH-1:0] pack_q, pack_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             keep_q, keep_d;
  logic             done_q, done_d;

  logic             w_handshake;
  logic             w_word_end;
  logic             w_stall;
  logic             w_scan;
  logic             w_scan_in;
  logic [WIDTH-1:0] w_pack_next;

  always_comb begin
    w_handshake = valid_q & data_ready;
    // The next capture closes a word: either the packer is full or it is
    // the last cell, which flushes a partial word.
    w_word_end  = (pos_q == c_last_pos) | (cnt_q == c_last_cell);
    // Hold the chain rather than overwrite a word the consumer has not
    // taken; a same-cycle handshake frees the holder, so data_ready is
    // used combinationally here.
    w_stall     = w_word_end & valid_q & ~data_ready;
    w_scan      = (state_q == ST_SHIFT) & ~w_stall;
    // Feeding the output bit back into the input rotates the chain; after
    // CELLS shifts every cell is back where it started.
    w_scan_in   = (state_q == ST_SHIFT) & keep_q & scan_out;
    // Upper bits above pos_q are always 0 here, so a partial word is
    // already zero-padded.
    w_pack_next = pack_q | (WIDTH'(scan_out) << pos_q);

    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    pack_d  = pack_q;
    data_d  = data_q;
    valid_d = valid_q;
    keep_d  = keep_q;
    done_d  = 1'b0;

    if (w_handshake) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          keep_d  = keep;
          cnt_d   = '0;
          pos_d   = '0;
          pack_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (w_scan) begin
          cnt_d = cnt_q + 1'b1;
          if (w_word_end) begin
            data_d  = w_pack_next;
            valid_d = 1'b1;
            pack_d  = '0;
            pos_d   = '0;
          end else begin
            pack_d  = w_pack_next;
            pos_d   = pos_q + 1'b1;
          end
          if (cnt_q == c_last_cell) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!valid_q || w_handshake) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      keep_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      keep_q  <= keep_d;
      done_q  <= done_d;
    end
  end

  assign scan       = w_scan;
  assign scan_in    = w_scan_in;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_life_scan_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_life_scan_reader                                      |
// | Description : Self-checking bench for life_scan_reader with a behav-   |
// |               ioural scan-chain model and an expected-word scoreboard. |
// |               Two instances: 16 cells and 12 cells, both 8-bit words.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_life_scan_reader;

  localparam int C16 = 16;
  localparam int C12 = 12;
  localparam int W   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: 16 cells ----------------
  logic           a_start, a_keep, a_scan_out, a_scan, a_scan_in;
  logic           a_valid, a_ready, a_busy, a_done;
  logic [W-1:0]   a_data;
  logic [C16-1:0] a_arr, a_load_val;
  logic           a_load, a_rdy, a_rand_en, a_rnd;
  logic [W-1:0]   q_a[$];

  life_scan_reader #(.CELLS(C16), .WIDTH(W)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .keep(a_keep),
    .scan_out(a_scan_out), .scan(a_scan), .scan_in(a_scan_in),
    .data(a_data), .data_valid(a_valid), .data_ready(a_ready),
    .busy(a_busy), .done(a_done)
  );

  // Chain model: bit 0 is the output end, scan_in enters at the top.
  assign a_scan_out = a_arr[0];
  always @(posedge clk) begin
    if (a_load)      a_arr <= a_load_val;
    else if (a_scan) a_arr <= {a_scan_in, a_arr[C16-1:1]};
  end

  assign a_ready = a_rand_en ? a_rnd : a_rdy;
  always @(posedge clk) begin
    #1;
    a_rnd = 1'($urandom_range(0, 1));
  end

  int a_ncyc = 0, a_hs_ncyc = 0, a_scans = 0, a_dones = 0, a_words = 0;
  logic         a_pv = 1'b0, a_pr = 1'b0;
  logic [W-1:0] a_pd = '0;
  always @(negedge clk) begin
    a_ncyc++;
    if (reset) begin
      if (a_pv && !a_pr) check("a_hold", a_data, a_pd);
      if (a_scan) a_scans++;
      if (a_done) begin
        a_dones++;
        check("a_done_lat", a_ncyc - a_hs_ncyc, 1);
      end
      if (a_valid && a_ready) begin
        a_words++;
        a_hs_ncyc = a_ncyc;
        if (q_a.size() == 0) check("a_extra_word", a_data, 32'hFFFF_FFFF);
        else                 check("a_word", a_data, q_a.pop_front());
      end
    end
    a_pv = a_valid && reset;
    a_pr = a_ready;
    a_pd = a_data;
  end

  // ---------------- instance B: 12 cells ----------------
  logic           b_start, b_keep, b_scan_out, b_scan, b_scan_in;
  logic           b_valid, b_ready, b_busy, b_done;
  logic [W-1:0]   b_data;
  logic [C12-1:0] b_arr, b_load_val;
  logic           b_load;
  logic [W-1:0]   q_b[$];

  life_scan_reader #(.CELLS(C12), .WIDTH(W)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .keep(b_keep),
    .scan_out(b_scan_out), .scan(b_scan), .scan_in(b_scan_in),
    .data(b_data), .data_valid(b_valid), .data_ready(b_ready),
    .busy(b_busy), .done(b_done)
  );

  assign b_scan_out = b_arr[0];
  always @(posedge clk) begin
    if (b_load)      b_arr <= b_load_val;
    else if (b_scan) b_arr <= {b_scan_in, b_arr[C12-1:1]};
  end

  int b_scans = 0, b_dones = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (b_scan) b_scans++;
      if (b_done) b_dones++;
      if (b_valid && b_ready) begin
        if (q_b.size() == 0) check("b_extra_word", b_data, 32'hFFFF_FFFF);
        else                 check("b_word", b_data, q_b.pop_front());
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic load_a(input logic [C16-1:0] pat);
    @(posedge clk); #1;
    a_load = 1'b1; a_load_val = pat;
    @(posedge clk); #1;
    a_load = 1'b0;
  endtask

  task automatic start_a(input logic kp);
    a_keep = kp; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_keep = 1'b0;
  endtask

  task automatic wait_done_a(input int max);
    int cyc;
    cyc = 0;
    while (!a_done && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    if (!a_done) check("a_done_timeout", 0, 1);
    @(posedge clk); #1;
    check("a_done_pulse_len", a_done, 0);
    check("a_busy_after", a_busy, 0);
  endtask

  task automatic push_a(input logic [C16-1:0] pat);
    for (int k = 0; k < C16 / W; k++) q_a.push_back(pat[W*k +: W]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, w0, cyc;
    logic [C16-1:0] pat;

    reset = 1'b0;
    a_start = 0; a_keep = 0; a_load = 0; a_load_val = '0; a_rdy = 1; a_rand_en = 0;
    b_start = 0; b_keep = 0; b_load = 0; b_load_val = '0; b_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scan",  a_scan, 0);
    check("rst_valid", a_valid, 0);
    check("rst_busy",  a_busy, 0);
    check("rst_done",  a_done, 0);
    check("rst_data",  a_data, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Destructive unload, fixed pattern.
    load_a(16'h3CA5);
    q_a.push_back(8'hA5); q_a.push_back(8'h3C);
    s0 = a_scans; d0 = a_dones;
    start_a(1'b0);
    wait_done_a(200);
    check("t1_scans", a_scans - s0, 16);
    check("t1_dones", a_dones - d0, 1);
    check("t1_qempty", q_a.size(), 0);
    check("t1_array", a_arr, 16'h0000);

    // Non-destructive unload.
    load_a(16'h3CA5);
    q_a.push_back(8'hA5); q_a.push_back(8'h3C);
    s0 = a_scans; d0 = a_dones;
    start_a(1'b1);
    wait_done_a(200);
    check("t2_scans", a_scans - s0, 16);
    check("t2_dones", a_dones - d0, 1);
    check("t2_array", a_arr, 16'h3CA5);

    // Backpressure after the first word.
    a_rdy = 1'b0;
    load_a(16'h3CA5);
    q_a.push_back(8'hA5); q_a.push_back(8'h3C);
    s0 = a_scans; d0 = a_dones;
    start_a(1'b0);
    cyc = 0;
    while (!a_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_first_valid", a_valid, 1);
    repeat (10) @(posedge clk);
    #1;
    check("t3_scan_stalled", a_scan, 0);
    check("t3_captures", a_scans - s0, 15);
    check("t3_hold_data", a_data, 8'hA5);
    check("t3_hold_valid", a_valid, 1);
    a_rdy = 1'b1;
    wait_done_a(200);
    check("t3_scans", a_scans - s0, 16);
    check("t3_dones", a_dones - d0, 1);
    check("t3_qempty", q_a.size(), 0);

    // Random patterns, random data_ready, start re-pulsed mid-shift.
    for (int kp = 0; kp < 2; kp++) begin
      pat = C16'($urandom_range(0, 65535));
      load_a(pat);
      push_a(pat);
      s0 = a_scans; d0 = a_dones;
      a_rand_en = 1'b1;
      start_a(kp[0]);
      repeat (4) @(posedge clk);
      #1;
      a_start = 1'b1; a_keep = ~kp[0];
      @(posedge clk); #1;
      a_start = 1'b0; a_keep = 1'b0;
      wait_done_a(400);
      a_rand_en = 1'b0;
      check("t4_scans", a_scans - s0, 16);
      check("t4_dones", a_dones - d0, 1);
      check("t4_qempty", q_a.size(), 0);
      check("t4_array", a_arr, kp[0] ? pat : 16'h0000);
    end

    // Reset mid-unload, then a clean unload.
    load_a(16'h3CA5);
    s0 = a_scans; w0 = a_words;
    start_a(1'b1);
    cyc = 0;
    while ((a_scans - s0) < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    reset = 1'b0;
    #1;
    check("t5_rst_scan",    a_scan, 0);
    check("t5_rst_scan_in", a_scan_in, 0);
    check("t5_rst_valid",   a_valid, 0);
    check("t5_rst_busy",    a_busy, 0);
    check("t5_rst_data",    a_data, 0);
    check("t5_rst_done",    a_done, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    check("t5_no_words", a_words - w0, 0);
    load_a(16'h5A0F);
    q_a.push_back(8'h0F); q_a.push_back(8'h5A);
    s0 = a_scans; d0 = a_dones;
    start_a(1'b0);
    wait_done_a(200);
    check("t5_scans", a_scans - s0, 16);
    check("t5_dones", a_dones - d0, 1);
    check("t5_qempty", q_a.size(), 0);
    check("t5_array", a_arr, 16'h0000);

    // 12-cell chain, all ones: one full word and one partial word.
    @(posedge clk); #1;
    b_load = 1'b1; b_load_val = 12'hFFF;
    @(posedge clk); #1;
    b_load = 1'b0;
    q_b.push_back(8'hFF); q_b.push_back(8'h0F);
    s0 = b_scans; d0 = b_dones;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("b_done_seen", b_done, 1);
    @(posedge clk); #1;
    check("b_scans", b_scans - s0, 12);
    check("b_dones", b_dones - d0, 1);
    check("b_qempty", q_b.size(), 0);
    check("b_array", b_arr, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
